// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_ctrl_pkg;

  localparam int XLEN_DEF = 32;
  localparam int INSTR_W  = 32;

  localparam logic [XLEN_DEF-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [XLEN_DEF-1:0] TRAP_PC  = 32'h0000_0100;

  // addi x0, x0, 0
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_npc_arb.sv
// Next-PC arbitration: trap > MEM redirect > ID jump, plus flush/misalign decode.
import fetch_ctrl_pkg::*;

module npc_arb #(
  parameter int              XLEN    = 32,
  parameter logic [XLEN-1:0] TRAP_PC = 32'h0000_0100
) (
  input  logic            enable,
  input  logic            trap,
  input  logic            mem_spl,
  input  logic [XLEN-1:0] mem_in1,
  input  logic            id_jump,
  input  logic [XLEN-1:0] id_target,
  output logic            redirect,
  output logic [XLEN-1:0] target,
  output logic            misaligned,
  output logic            if_id_flush,
  output logic            id_ex_flush
);

  logic [XLEN-1:0] raw_target;

  always_comb begin
    raw_target = id_target;
    if (trap)         raw_target = TRAP_PC;
    else if (mem_spl) raw_target = mem_in1;
  end

  // Everything is suppressed while the fetch stage is held in reset.
  assign redirect    = enable & (trap | mem_spl | id_jump);
  assign target      = {raw_target[XLEN-1:2], 2'b00};
  assign misaligned  = redirect & (raw_target[1:0] != 2'b00);
  assign if_id_flush = redirect;
  assign id_ex_flush = enable & (trap | mem_spl);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC register, imem handshake, stall/redirect handling.
import fetch_ctrl_pkg::*;

module fetch_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = fetch_ctrl_pkg::RESET_PC,
  parameter logic [XLEN-1:0] TRAP_PC  = fetch_ctrl_pkg::TRAP_PC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               trap,
  input  logic               mem_spl,
  input  logic [XLEN-1:0]    mem_in1,
  input  logic               id_jump,
  input  logic [XLEN-1:0]    id_target,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               imem_req,
  output logic [XLEN-1:0]    if_PC,
  output logic [INSTR_W-1:0] if_instr,
  output logic               if_valid,
  output logic               if_id_flush,
  output logic               id_ex_flush,
  output logic               misalign
);

  fetch_state_t       state_reg, state_next;
  logic [XLEN-1:0]    pc_reg, pc_next;
  logic [XLEN-1:0]    pend_reg, pend_next;
  logic               pend_valid_reg, pend_valid_next;
  logic [INSTR_W-1:0] instr_reg, instr_next;
  logic               valid_reg, valid_next;
  logic               misalign_reg, misalign_next;

  logic               redirect;
  logic [XLEN-1:0]    target;
  logic               tgt_misaligned;

  npc_arb #(.XLEN(XLEN), .TRAP_PC(TRAP_PC)) u_npc_arb (
    .enable      (reset),
    .trap        (trap),
    .mem_spl     (mem_spl),
    .mem_in1     (mem_in1),
    .id_jump     (id_jump),
    .id_target   (id_target),
    .redirect    (redirect),
    .target      (target),
    .misaligned  (tgt_misaligned),
    .if_id_flush (if_id_flush),
    .id_ex_flush (id_ex_flush)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= BOOT;
      pc_reg         <= RESET_PC;
      pend_reg       <= RESET_PC;
      pend_valid_reg <= 1'b0;
      instr_reg      <= '0;
      valid_reg      <= 1'b0;
      misalign_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      pend_reg       <= pend_next;
      pend_valid_reg <= pend_valid_next;
      instr_reg      <= instr_next;
      valid_reg      <= valid_next;
      misalign_reg   <= misalign_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    pend_next       = pend_reg;
    pend_valid_next = pend_valid_reg;
    instr_next      = instr_reg;
    valid_next      = valid_reg;
    misalign_next   = tgt_misaligned;

    unique case (state_reg)
      BOOT: begin
        state_next = FETCH;
        if (redirect) pc_next = target;
      end
      FETCH: begin
        if (redirect) begin
          valid_next = 1'b0;
          if (imem_ready) begin
            pc_next = target;
          end else begin
            pend_next       = target;
            pend_valid_next = 1'b1;
            state_next      = DRAIN;
          end
        end else if (imem_ready) begin
          instr_next = imem_rdata;
          valid_next = 1'b1;
          if (stall) state_next = HOLD;
          else       pc_next    = pc_reg + XLEN'(4);
        end else if (!stall) begin
          valid_next = 1'b0;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_next    = target;
          valid_next = 1'b0;
          state_next = FETCH;
        end else if (!stall) begin
          pc_next    = pc_reg + XLEN'(4);
          valid_next = 1'b0;
          state_next = FETCH;
        end
      end
      DRAIN: begin
        // The in-flight response belongs to the squashed path and is dropped.
        if (imem_ready) begin
          pc_next         = redirect ? target : pend_reg;
          pend_valid_next = 1'b0;
          state_next      = FETCH;
        end else if (redirect) begin
          pend_next = target;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  assign imem_req = (state_reg == FETCH) || (state_reg == DRAIN);
  assign if_PC    = pc_reg;
  assign if_instr = instr_reg;
  assign if_valid = valid_reg;
  assign misalign = misalign_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed-vector bench for fetch_ctrl with a combinational imem model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        trap;
  logic        mem_spl;
  logic [31:0] mem_in1;
  logic        id_jump;
  logic [31:0] id_target;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] if_PC;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        misalign;

  int vectors = 0;
  int miscompares = 0;

  fetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .trap        (trap),
    .mem_spl     (mem_spl),
    .mem_in1     (mem_in1),
    .id_jump     (id_jump),
    .id_target   (id_target),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .imem_req    (imem_req),
    .if_PC       (if_PC),
    .if_instr    (if_instr),
    .if_valid    (if_valid),
    .if_id_flush (if_id_flush),
    .id_ex_flush (id_ex_flush),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr ^ 32'h1357_0000;
  endfunction

  assign imem_rdata = mem_word(if_PC);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redirects();
    trap = 1'b0; mem_spl = 1'b0; id_jump = 1'b0;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; clear_redirects();
    mem_in1 = '0; id_target = '0; imem_ready = 1'b1;

    // Reset state, with a trap request that must not leak through
    tick(); tick();
    trap = 1'b1; #1;
    check("rst_pc",      if_PC,       32'h0);
    check("rst_valid",   32'(if_valid), 32'h0);
    check("rst_req",     32'(imem_req), 32'h0);
    check("rst_instr",   if_instr,    32'h0);
    check("rst_ifflush", 32'(if_id_flush), 32'h0);
    trap = 1'b0;

    // Sequential fetch
    reset = 1'b1;
    tick();
    check("boot_pc",   if_PC, 32'h0);
    check("boot_req",  32'(imem_req), 32'h1);
    check("boot_val",  32'(if_valid), 32'h0);
    tick();
    check("seq_pc4",   if_PC, 32'h4);
    check("seq_val",   32'(if_valid), 32'h1);
    check("seq_ins0",  if_instr, mem_word(32'h0));
    tick();
    check("seq_pc8",   if_PC, 32'h8);

    // Stall for three cycles at PC 8
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_pc",  if_PC, 32'h8);
      check("hold_ins", if_instr, mem_word(32'h8));
      check("hold_req", 32'(imem_req), 32'h0);
    end
    stall = 1'b0;
    tick();
    check("resume_pc", if_PC, 32'hC);
    check("resume_req", 32'(imem_req), 32'h1);
    tick();
    check("resume_pc2", if_PC, 32'h10);
    check("resume_ins", if_instr, mem_word(32'hC));

    // Delayed ready with a MEM redirect during the wait
    imem_ready = 1'b0;
    tick();
    check("wait_pc",  if_PC, 32'h10);
    check("wait_val", 32'(if_valid), 32'h0);
    mem_spl = 1'b1; mem_in1 = 32'h40; #1;
    check("spl_ifflush", 32'(if_id_flush), 32'h1);
    check("spl_exflush", 32'(id_ex_flush), 32'h1);
    tick();
    clear_redirects(); #1;
    check("drain_req",     32'(imem_req), 32'h1);
    check("drain_pc",      if_PC, 32'h10);
    check("drain_noflush", 32'({if_id_flush, id_ex_flush}), 32'h0);
    tick();
    imem_ready = 1'b1;
    tick();
    check("drain_done_pc", if_PC, 32'h40);
    check("stale_drop",    if_instr, mem_word(32'hC));
    check("stale_val",     32'(if_valid), 32'h0);
    tick();
    check("post_drain_pc",  if_PC, 32'h44);
    check("post_drain_ins", if_instr, mem_word(32'h40));

    // All three redirect sources together
    trap = 1'b1; mem_spl = 1'b1; mem_in1 = 32'h80; id_jump = 1'b1; id_target = 32'h200; #1;
    check("all_flushes", 32'({if_id_flush, id_ex_flush}), 32'h3);
    tick();
    clear_redirects();
    check("trap_pc",  if_PC, 32'h100);
    check("trap_mis", 32'(misalign), 32'h0);
    check("trap_val", 32'(if_valid), 32'h0);

    // Misaligned ID jump
    id_jump = 1'b1; id_target = 32'h22; #1;
    check("jmp_flushes", 32'({if_id_flush, id_ex_flush}), 32'h2);
    tick();
    clear_redirects();
    check("jmp_pc",  if_PC, 32'h20);
    check("jmp_mis", 32'(misalign), 32'h1);
    tick();
    check("jmp_mis_clr", 32'(misalign), 32'h0);
    check("jmp_pc_seq",  if_PC, 32'h24);
    check("jmp_ins",     if_instr, mem_word(32'h20));

    // Wrap-around at top of address space
    id_jump = 1'b1; id_target = 32'hFFFF_FFFC;
    tick();
    clear_redirects();
    check("wrap_top", if_PC, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc",  if_PC, 32'h0);
    check("wrap_ins", if_instr, mem_word(32'hFFFF_FFFC));

    // Reset asserted in the middle of a drain
    imem_ready = 1'b0; mem_spl = 1'b1; mem_in1 = 32'h300;
    tick();
    clear_redirects();
    check("pre_rst_req", 32'(imem_req), 32'h1);
    reset = 1'b0; #1;
    check("mid_rst_pc",  if_PC, 32'h0);
    check("mid_rst_val", 32'(if_valid), 32'h0);
    check("mid_rst_req", 32'(imem_req), 32'h0);
    imem_ready = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    check("rerun_pc",  if_PC, 32'h0);
    check("rerun_req", 32'(imem_req), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
